// File: rtl/pe_alu_pkg.sv
// Shared opcode encodings, latency constant and stage-1 control payload for the PE ALU pipeline.
package pe_alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_MUL     = 4'd5;
    localparam logic [3:0] OP_MUL_ADD = 4'd6;
    localparam logic [3:0] OP_SEL     = 4'd7;
    localparam logic [3:0] OP_NOT     = 4'd8;

    // Cycles from input acceptance to out_valid with out_ready held high.
    localparam int unsigned RESULT_LATENCY = 2;

    typedef struct packed {
        logic valid;
        logic sel;
        logic clr;
    } s1_ctrl_t;

endpackage

// File: rtl/pe_alu_pipe_if.sv
// Input/output handshake bus plus static config for pe_alu_pipe.
interface pe_alu_pipe_if #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NoConfigBits = 4
) ();

    logic [NoConfigBits-1:0] ALU_func;
    logic [WIDTH-1:0]        data_in1;
    logic [WIDTH-1:0]        data_in2;
    logic                    data_in3;
    logic                    acc_clr;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        data_out;
    logic                    carry_out;
    logic                    zero_out;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  ALU_func, data_in1, data_in2, data_in3, acc_clr, in_valid, out_ready,
        output in_ready, data_out, carry_out, zero_out, out_valid
    );

    modport master (
        output ALU_func, data_in1, data_in2, data_in3, acc_clr, in_valid, out_ready,
        input  in_ready, data_out, carry_out, zero_out, out_valid
    );

endinterface

// File: rtl/pe_alu_core.sv
// Combinational ALU: decodes the static opcode and produces {carry, result} for one beat.
module pe_alu_core
    import pe_alu_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NoConfigBits = 4
) (
    input  logic [NoConfigBits-1:0] func,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    sel,
    input  logic [WIDTH-1:0]        acc,
    output logic [WIDTH-1:0]        result_c,
    output logic                    carry_c
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] mul_lo;

    // Add/sub run one bit wider so the top bit is carry or borrow.
    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        wide     = '0;
        mul_lo   = a * b;
        case (func)
            NoConfigBits'(OP_ADD): begin
                wide     = {1'b0, a} + {1'b0, b};
                result_c = wide[WIDTH-1:0];
                carry_c  = wide[WIDTH];
            end
            NoConfigBits'(OP_SUB): begin
                wide     = {1'b0, a} - {1'b0, b};
                result_c = wide[WIDTH-1:0];
                carry_c  = wide[WIDTH];
            end
            NoConfigBits'(OP_AND):     result_c = a & b;
            NoConfigBits'(OP_OR):      result_c = a | b;
            NoConfigBits'(OP_XOR):     result_c = a ^ b;
            NoConfigBits'(OP_MUL):     result_c = mul_lo;
            NoConfigBits'(OP_MUL_ADD): result_c = mul_lo + acc;
            NoConfigBits'(OP_SEL):     result_c = sel ? a : b;
            NoConfigBits'(OP_NOT):     result_c = ~a;
            default: ;
        endcase
    end

endmodule

// File: rtl/pe_alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake and a MUL_ADD accumulator.
module pe_alu_pipe
    import pe_alu_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NoConfigBits = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_alu_pipe_if.slave bus
);

    s1_ctrl_t         s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_carry;
    logic             s2_zero;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             en;
    logic             s1_move;
    logic             is_mul_add;

    // Whole pipe advances together; a stalled output freezes both stages.
    assign en         = !s2_valid || bus.out_ready;
    assign s1_move    = en && s1_ctrl.valid;
    assign is_mul_add = (bus.ALU_func == NoConfigBits'(OP_MUL_ADD));
    assign acc_eff    = s1_ctrl.clr ? '0 : acc;

    assign bus.in_ready  = en;
    assign bus.out_valid = s2_valid;
    assign bus.data_out  = s2_data;
    assign bus.carry_out = s2_carry;
    assign bus.zero_out  = s2_zero;

    pe_alu_core #(
        .WIDTH       (WIDTH),
        .NoConfigBits(NoConfigBits)
    ) u_core (
        .func    (bus.ALU_func),
        .a       (s1_a),
        .b       (s1_b),
        .sel     (s1_ctrl.sel),
        .acc     (acc_eff),
        .result_c(core_result),
        .carry_c (core_carry)
    );

    // Stage 1: operand capture; a bubble only clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (en) begin
            s1_ctrl.valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_ctrl.sel <= bus.data_in3;
                s1_ctrl.clr <= bus.acc_clr;
                s1_a        <= bus.data_in1;
                s1_b        <= bus.data_in2;
            end
        end
    end

    // Stage 2: result and flags, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_carry <= 1'b0;
            s2_zero  <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_ctrl.valid;
            if (s1_ctrl.valid) begin
                s2_data  <= core_result;
                s2_carry <= core_carry;
                s2_zero  <= (core_result == '0);
            end
        end
    end

    // Accumulator follows each MUL_ADD beat as it leaves stage 1, so the next beat chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s1_move) begin
            if (is_mul_add) begin
                acc <= core_result;
            end else if (s1_ctrl.clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_alu_pipe.sv
// Self-checking bench for pe_alu_pipe: vector table, corner sequences and random traffic via a scoreboard.
module tb_pe_alu_pipe;
    import pe_alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         cy;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         c;
        logic [W-1:0] d;
        logic         cy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pe_alu_pipe_if #(.WIDTH(W), .NoConfigBits(4)) bus ();

    pe_alu_pipe #(.WIDTH(W), .NoConfigBits(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    int           pop_cyc[$];
    exp_t         next_exp;
    bit           use_model;
    bit           chk_lat;
    logic [W-1:0] m_acc;
    int           cyc;
    int           total;
    int           bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c, input logic [W-1:0] accv);
        exp_t        e;
        logic [63:0] p;
        e.d = '0;
        e.cy = 1'b0;
        e.cyc = 0;
        e.chk_lat = 1'b0;
        p = {32'd0, a} * {32'd0, b};
        case (f)
            4'd0: {e.cy, e.d} = {1'b0, a} + {1'b0, b};
            4'd1: begin e.d = a - b; e.cy = (a < b); end
            4'd2: e.d = a & b;
            4'd3: e.d = a | b;
            4'd4: e.d = a ^ b;
            4'd5: e.d = p[31:0];
            4'd6: e.d = p[31:0] + (c ? 32'd0 : accv);
            4'd7: e.d = s ? a : b;
            4'd8: e.d = ~a;
            default: ;
        endcase
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got data_out=%0h with nothing expected (cycle %0d)", bus.data_out, cyc);
            return;
        end
        e = q.pop_front();
        check("data_out", 64'(bus.data_out), 64'(e.d));
        check("carry_out", 64'(bus.carry_out), 64'(e.cy));
        check("zero_out", 64'(bus.zero_out), 64'(e.d == '0));
        if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(RESULT_LATENCY));
        pop_cyc.push_back(cyc);
    endtask

    // One cycle: inputs are already driven at the negedge; record transfers that the next posedge performs.
    task automatic tick(output bit accepted);
        exp_t e;
        #1;
        accepted = 1'b0;
        if (bus.out_valid && bus.out_ready) pop_check();
        if (bus.in_valid && bus.in_ready) begin
            if (use_model)
                e = model(bus.ALU_func, bus.data_in1, bus.data_in2, bus.data_in3, bus.acc_clr, m_acc);
            else
                e = next_exp;
            e.cyc = cyc;
            e.chk_lat = chk_lat;
            q.push_back(e);
            if (bus.ALU_func == OP_MUL_ADD)
                m_acc = bus.data_in1 * bus.data_in2 + (bus.acc_clr ? 32'd0 : m_acc);
            else if (bus.acc_clr)
                m_acc = '0;
            accepted = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        bus.in_valid = 1'b1;
        bus.data_in1 = a;
        bus.data_in2 = b;
        bus.data_in3 = s;
        bus.acc_clr  = c;
    endtask

    task automatic drain();
        bit acc_b;
        bus.in_valid  = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(acc_b);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results still pending want 0", q.size());
            q.delete();
        end
        tick(acc_b);
        tick(acc_b);
    endtask

    task automatic send_one(input vec_t v);
        bit acc_b;
        next_exp.d  = v.d;
        next_exp.cy = v.cy;
        drive(v.a, v.b, v.s, v.c);
        acc_b = 1'b0;
        for (int i = 0; i < 10 && !acc_b; i++) tick(acc_b);
        if (!acc_b) check("accept_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    vec_t tbl[16];

    initial begin
        bit           acc_b;
        int           idx;
        bit           have_held;
        logic [W-1:0] held;
        logic [3:0]   rfuncs[10];
        vec_t         v;
        vec_t         beats[3];

        tbl[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1};
        tbl[1]  = '{4'd0, 32'd5,         32'd7,         1'b0, 1'b0, 32'd12,        1'b0};
        tbl[2]  = '{4'd1, 32'd3,         32'd5,         1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};
        tbl[3]  = '{4'd1, 32'd5,         32'd3,         1'b0, 1'b0, 32'd2,         1'b0};
        tbl[4]  = '{4'd1, 32'd7,         32'd7,         1'b0, 1'b0, 32'd0,         1'b0};
        tbl[5]  = '{4'd5, 32'h1_0000,    32'h1_0000,    1'b0, 1'b0, 32'h0,         1'b0};
        tbl[6]  = '{4'd5, 32'h1234,      32'h10,        1'b0, 1'b0, 32'h1_2340,    1'b0};
        tbl[7]  = '{4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b0, 32'h00F0_000F, 1'b0};
        tbl[8]  = '{4'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b0, 32'hFFF0_0FFF, 1'b0};
        tbl[9]  = '{4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b0, 32'hFF00_0FF0, 1'b0};
        tbl[10] = '{4'd7, 32'hA,         32'hB,         1'b0, 1'b0, 32'hB,         1'b0};
        tbl[11] = '{4'd7, 32'hA,         32'hB,         1'b1, 1'b0, 32'hA,         1'b0};
        tbl[12] = '{4'd8, 32'h0,         32'h5,         1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
        tbl[13] = '{4'd8, 32'hFFFF_FFFF, 32'h5,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[14] = '{4'd12, 32'd3,        32'd4,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[15] = '{4'd6, 32'd3,         32'd4,         1'b0, 1'b1, 32'd12,        1'b0};

        bus.ALU_func  = 4'd0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;
        bus.data_in3  = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        use_model = 1'b0;
        chk_lat   = 1'b1;
        m_acc     = '0;
        cyc = 0;
        total = 0;
        bad = 0;
        next_exp = '{default: '0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_data_out", 64'(bus.data_out), 64'(0));
        check("rst_zero_out", 64'(bus.zero_out), 64'(0));
        check("rst_carry_out", 64'(bus.carry_out), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, one beat per opcode with full drain in between
        foreach (tbl[i]) begin
            bus.ALU_func = tbl[i].f;
            send_one(tbl[i]);
            drain();
        end

        // MUL_ADD chain: 6, 26, 27 on consecutive cycles
        bus.ALU_func = OP_MUL_ADD;
        pop_cyc.delete();
        beats[0] = '{4'd6, 32'd2, 32'd3, 1'b0, 1'b1, 32'd6,  1'b0};
        beats[1] = '{4'd6, 32'd4, 32'd5, 1'b0, 1'b0, 32'd26, 1'b0};
        beats[2] = '{4'd6, 32'd1, 32'd1, 1'b0, 1'b0, 32'd27, 1'b0};
        for (int i = 0; i < 3; i++) begin
            next_exp.d  = beats[i].d;
            next_exp.cy = 1'b0;
            drive(beats[i].a, beats[i].b, 1'b0, beats[i].c);
            tick(acc_b);
        end
        drain();
        check("chain_count", 64'(pop_cyc.size()), 64'(3));
        if (pop_cyc.size() == 3) begin
            check("chain_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'(1));
            check("chain_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'(1));
        end

        // acc_clr on a non-MUL_ADD beat zeroes the accumulator
        bus.ALU_func = OP_ADD;
        v = '{4'd0, 32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 1'b0};
        send_one(v);
        drain();
        bus.ALU_func = OP_MUL_ADD;
        v = '{4'd6, 32'd2, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0};
        send_one(v);
        drain();

        // Output stall: 3 beats offered over 5 blocked cycles, only 2 taken
        chk_lat = 1'b0;
        bus.ALU_func  = OP_ADD;
        bus.out_ready = 1'b0;
        beats[0] = '{4'd0, 32'd1, 32'd2, 1'b0, 1'b0, 32'd3,  1'b0};
        beats[1] = '{4'd0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7,  1'b0};
        beats[2] = '{4'd0, 32'd5, 32'd6, 1'b0, 1'b0, 32'd11, 1'b0};
        idx = 0;
        have_held = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            next_exp.d  = beats[idx].d;
            next_exp.cy = 1'b0;
            drive(beats[idx].a, beats[idx].b, 1'b0, 1'b0);
            tick(acc_b);
            if (acc_b) idx++;
            if (bus.out_valid) begin
                if (!have_held) begin
                    held = bus.data_out;
                    have_held = 1'b1;
                end else begin
                    check("stall_hold", 64'(bus.data_out), 64'(held));
                end
            end
        end
        check("stall_accepted", 64'(idx), 64'(2));
        check("stall_held_value", 64'(held), 64'(3));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            next_exp.d  = beats[idx].d;
            next_exp.cy = 1'b0;
            drive(beats[idx].a, beats[idx].b, 1'b0, 1'b0);
            tick(acc_b);
            if (acc_b) idx++;
        end
        check("stall_all_sent", 64'(idx), 64'(3));
        drain();

        // Reset with two beats in flight
        bus.ALU_func = OP_MUL_ADD;
        next_exp.d = 32'd99;
        next_exp.cy = 1'b0;
        drive(32'd7, 32'd7, 1'b0, 1'b0);
        tick(acc_b);
        tick(acc_b);
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("mid_rst_data_out", 64'(bus.data_out), 64'(0));
        check("mid_rst_zero_out", 64'(bus.zero_out), 64'(0));
        q.delete();
        m_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{4'd6, 32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0};
        send_one(v);
        drain();

        // Random traffic per opcode against the reference model
        use_model = 1'b1;
        rfuncs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
        foreach (rfuncs[k]) begin
            bus.ALU_func = rfuncs[k];
            for (int i = 0; i < 30; i++) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.data_in1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                bus.data_in2  = ($urandom_range(0, 3) == 0) ? bus.data_in1 : $urandom;
                bus.data_in3  = 1'($urandom_range(0, 1));
                bus.acc_clr   = ($urandom_range(0, 4) == 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                tick(acc_b);
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_alu_pipe.md
PE_ALU_PIPE -- requirements
Module: pe_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 Parameter NoConfigBits, default 4, width of ALU_func config field.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ALU_func  input  NoConfigBits  static config bits (FABulous CONFIG_BIT), FEATURE "ADD;SUB;AND;OR;XOR;MUL;MUL_ADD;SEL;NOT".
REQ-006 data_in1, data_in2  input  WIDTH each  operands (FABulous BUS).
REQ-007 data_in3  input  1  select operand for SEL.
REQ-008 acc_clr  input  1  qualifies the input beat; zeroes accumulator before MUL_ADD uses it.
REQ-009 in_valid  input  1 / in_ready  output  1  input handshake.
REQ-010 data_out  output  WIDTH  registered result.
REQ-011 carry_out  output  1  carry (ADD), borrow (SUB), 0 otherwise.
REQ-012 zero_out  output  1  high when data_out is all zeros.
REQ-013 out_valid  output  1 / out_ready  input  1  output handshake.

Function
REQ-014 Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, MUL=5, MUL_ADD=6, SEL=7, NOT=8; codes 9-15 produce result 0, carry 0.
REQ-015 Two-stage pipeline: S1 registers operands, data_in3, acc_clr; S2 registers result and flags.
REQ-016 Beat accepted when in_valid && in_ready; result appears with out_valid high exactly 2 cycles later if out_ready stayed high.
REQ-017 Pipeline enable en = !out_valid || out_ready; in_ready = en; no stage advances when en low.
REQ-018 When en high and in_valid low, a bubble (valid=0) enters S1; S2 valid follows S1 valid.
REQ-019 data_out, carry_out, zero_out hold stable while out_valid && !out_ready.
REQ-020 ADD/SUB computed WIDTH+1 bits wide; MSB drives carry_out; SUB borrow = 1 when data_in1 < data_in2 unsigned.
REQ-021 MUL and MUL_ADD keep the low WIDTH bits of the unsigned product; high bits discarded.
REQ-022 MUL_ADD result = (data_in1*data_in2) + acc, acc treated as 0 when the beat's acc_clr is set; truncated to WIDTH.
REQ-023 Accumulator register acc (WIDTH) updated to the MUL_ADD result only when that beat moves S1->S2; untouched by other ops and by bubbles.
REQ-024 Back-to-back MUL_ADD beats chain with no bubble: beat N+1 sees acc including beat N.
REQ-025 acc_clr on a non-MUL_ADD beat clears acc to 0 when that beat moves S1->S2.
REQ-026 SEL: data_in3 ? data_in1 : data_in2; NOT: ~data_in1; AND/OR/XOR bitwise.
REQ-027 ALU_func is static during operation; change while pipeline non-empty gives undefined results for in-flight beats only.

Reset
REQ-028 rst_n low asynchronously clears S1/S2 valid, acc, data_out, carry_out, zero_out to 0; zero_out reset value 0 despite zero data.
REQ-029 in_ready is 1 during and after reset; in-flight beats at reset are discarded, never emitted.
REQ-030 Reset release is synchronised by the integrator; block needs no internal synchroniser.

Structure
REQ-031 Package pe_alu_pkg holds the opcode localparams and result-latency constant (2).
REQ-032 One sub-module pe_alu_core: combinational op decode producing {carry, result}; pipeline, handshake and accumulator live in pe_alu_pipe.

Verification
REQ-033 ADD 0xFFFFFFFF+0x1, out_ready=1 -> 2 cycles later data_out=0, carry_out=1, zero_out=1.
REQ-034 SUB 3-5 -> data_out=0xFFFFFFFE, carry_out=1; MUL 0x10000*0x10000 -> data_out=0.
REQ-035 MUL_ADD beats (2,3,acc_clr=1),(4,5),(1,1) consecutive -> outputs 6, 26, 27 on consecutive cycles.
REQ-036 out_ready low 5 cycles with 3 beats offered -> only 2 accepted, data_out stable, no loss or duplication after release.
REQ-037 rst_n pulsed with 2 beats in flight -> out_valid=0 immediately, acc=0, next MUL_ADD 2*2 -> 4.
REQ-038 SEL with data_in3=0/1, operands 0xA/0xB -> 0xB then 0xA; opcode 12 -> 0, carry 0.
